// File: rtl/dst_uart_dump_if.sv
// dst_uart_dump_if: start/status, RAM read port and UART line of the destination dump stage
interface dst_uart_dump_if #(
  parameter int ADDR_BITS = 10
);
  logic                 start;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [23:0]          mem_do;
  logic                 tx;
  logic                 busy;
  logic                 done;
  modport master (input start, mem_do, output mem_addr, tx, busy, done);
  modport slave  (output start, mem_do, input mem_addr, tx, busy, done);
endinterface

// File: rtl/dst_uart_dump.sv
// dst_uart_dump: reads gray bytes from the destination RAM and sends them as 8N1 UART frames; DST_UART_DUMP_CHECKSUM_EN appends an XOR checksum frame
module dst_uart_dump #(
  parameter int ADDR_BITS    = 10,
  parameter int PIXELS       = 1024,
  parameter int CLKS_PER_BIT = 434
) (
  input logic             clk,
  input logic             reset,
  dst_uart_dump_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef DST_UART_DUMP_CHECKSUM_EN
  typedef enum logic [3:0] {IDLE, FETCH, WAIT, LOAD, START, DATA, STOP, CSUM, DONE} state_t;
`else
  typedef enum logic [3:0] {IDLE, FETCH, WAIT, LOAD, START, DATA, STOP, DONE} state_t;
`endif
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n, cnt_inc;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [ADDR_BITS-1:0] idx, idx_n, addr, addr_n;
  logic [7:0]           sh, sh_n;
  logic                 tx, tx_n;
  logic                 tc, last;
`ifdef DST_UART_DUMP_CHECKSUM_EN
  logic [7:0]           csum, csum_n;
  logic                 in_csum, in_csum_n;
`endif
  logic                 unused_hi;
  assign unused_hi    = &{1'b0, bus.mem_do[23:8]};
  assign tc           = cnt == CW'(CLKS_PER_BIT - 1);
  assign cnt_inc      = tc ? '0 : cnt + 1'b1;
  assign last         = idx == ADDR_BITS'(PIXELS - 1);
  assign bus.mem_addr = addr;
  assign bus.tx       = tx;
  assign bus.busy     = state != IDLE && state != DONE;
  assign bus.done     = state == DONE;
  // next-state, line bit and datapath updates; start/stop bits are loaded one cycle ahead so tx stays registered
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    idx_n     = idx;
    addr_n    = addr;
    sh_n      = sh;
    tx_n      = tx;
`ifdef DST_UART_DUMP_CHECKSUM_EN
    csum_n    = csum;
    in_csum_n = in_csum;
`endif
    case (state)
      IDLE: if (bus.start) begin
        state_n   = FETCH;
        idx_n     = '0;
        cnt_n     = '0;
`ifdef DST_UART_DUMP_CHECKSUM_EN
        csum_n    = '0;
        in_csum_n = 1'b0;
`endif
      end
      FETCH: begin
        addr_n  = idx;
        state_n = WAIT;
      end
      WAIT: state_n = LOAD;
      LOAD: begin
        sh_n    = bus.mem_do[7:0];
        tx_n    = 1'b0;
        cnt_n   = '0;
        state_n = START;
`ifdef DST_UART_DUMP_CHECKSUM_EN
        csum_n  = csum ^ bus.mem_do[7:0];
`endif
      end
`ifdef DST_UART_DUMP_CHECKSUM_EN
      START, CSUM: begin
`else
      START: begin
`endif
        cnt_n = cnt_inc;
        if (tc) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = sh[0];
          sh_n      = {1'b0, sh[7:1]};
        end
      end
      DATA: begin
        cnt_n = cnt_inc;
        if (tc) begin
          state_n   = bit_idx == 3'd7 ? STOP : DATA;
          tx_n      = bit_idx == 3'd7 ? 1'b1 : sh[0];
          bit_idx_n = bit_idx + 1'b1;
          sh_n      = {1'b0, sh[7:1]};
        end
      end
      STOP: begin
        cnt_n = cnt_inc;
        if (tc) begin
`ifdef DST_UART_DUMP_CHECKSUM_EN
          if (in_csum) state_n = DONE;
          else if (last) begin
            state_n   = CSUM;
            sh_n      = csum;
            tx_n      = 1'b0;
            in_csum_n = 1'b1;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = FETCH;
          end
`else
          if (last) state_n = DONE;
          else begin
            idx_n   = idx + 1'b1;
            state_n = FETCH;
          end
`endif
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers; reset idles the line high at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      idx     <= '0;
      addr    <= '0;
      sh      <= '0;
      tx      <= 1'b1;
`ifdef DST_UART_DUMP_CHECKSUM_EN
      csum    <= '0;
      in_csum <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      idx     <= idx_n;
      addr    <= addr_n;
      sh      <= sh_n;
      tx      <= tx_n;
`ifdef DST_UART_DUMP_CHECKSUM_EN
      csum    <= csum_n;
      in_csum <= in_csum_n;
`endif
    end
  end
endmodule

// File: tb/tb_dst_uart_dump.sv
// tb_dst_uart_dump: randomized bench decoding the UART line against a queue model of the RAM dump
module tb_dst_uart_dump;
  localparam int AB = 10;
  localparam int P  = 3;
  localparam int C  = 4;
`ifdef DST_UART_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int EXP_LEN = 1 + P * (3 + 10 * C) + CS * 10 * C;
  logic clk = 1'b0;
  logic reset = 1'b1;
  dst_uart_dump_if #(.ADDR_BITS(AB)) bus();
  dst_uart_dump #(.ADDR_BITS(AB), .PIXELS(P), .CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  logic [23:0] ram [1 << AB];
  // synchronous-read RAM model
  always @(posedge clk) bus.mem_do <= ram[bus.mem_addr];
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  bit mon_en = 1'b0;
  logic [7:0] rx_q[$];
  int ok_q[$];
  int addr_q[$];
  // UART receiver: mid-bit sampling of each frame, noting the address on the bus at frame start
  initial forever begin
    logic [7:0] b;
    int ok;
    int a;
    @(negedge clk);
    if (mon_en && bus.tx === 1'b0) begin
      a = int'(bus.mem_addr);
      repeat (C / 2) @(negedge clk);
      ok = int'(bus.tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        b[i] = bus.tx;
      end
      repeat (C) @(negedge clk);
      ok = int'(ok != 0 && bus.tx === 1'b1);
      rx_q.push_back(b);
      ok_q.push_back(ok);
      addr_q.push_back(a);
    end
  end
  task automatic do_run(input bit repulse);
    logic [7:0] exp_b[$];
    logic [7:0] x = 8'h00;
    int done_cnt = 0, done_at = -1, first_low = -1, busy_bad = 0, busy_late = 0;
    for (int i = 0; i < P; i++) begin
      exp_b.push_back(ram[i][7:0]);
      x ^= ram[i][7:0];
    end
    if (CS != 0) exp_b.push_back(x);
    rx_q.delete();
    ok_q.delete();
    addr_q.delete();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= EXP_LEN + 20; k++) begin
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (first_low < 0 && !bus.tx) first_low = k;
      if (k < EXP_LEN && !bus.busy) busy_bad++;
      if (k >= EXP_LEN && bus.busy) busy_late++;
      bus.start = repulse && k <= EXP_LEN &&
                  (k == 20 || k == 60 || k == EXP_LEN || $urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, EXP_LEN);
    check("first_start_bit", first_low, 4);
    check("busy_low_in_run", busy_bad, 0);
    check("busy_after_done", busy_late, 0);
    check("frame_count", rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      check($sformatf("byte%0d", i), rx_q[i], exp_b[i]);
      check($sformatf("framing%0d", i), ok_q[i], 1);
      check($sformatf("addr%0d", i), addr_q[i], i < P ? i : P - 1);
    end
    check("addr_hold_idle", bus.mem_addr, P - 1);
  endtask
  initial begin
    int bad_tx, bad_busy, bad_done;
    bus.start = 1'b0;
    for (int i = 0; i < (1 << AB); i++) ram[i] = 24'($urandom());
    ram[0] = 24'h000000;
    ram[1] = 24'hA5A5A5;
    ram[2] = 24'hFFFF3C;
    repeat (3) @(negedge clk);
    check("reset_tx", bus.tx, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_addr", bus.mem_addr, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    bad_tx = 0;
    bad_busy = 0;
    bad_done = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) bad_tx++;
      if (bus.busy !== 1'b0) bad_busy++;
      if (bus.done !== 1'b0) bad_done++;
    end
    check("idle_tx", bad_tx, 0);
    check("idle_busy", bad_busy, 0);
    check("idle_done", bad_done, 0);
    do_run(1'b0);
    do_run(1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (55) @(negedge clk);
    check("pre_reset_tx", bus.tx, 0);
    #1 reset = 1'b1;
    #1;
    check("midreset_tx", bus.tx, 1);
    check("midreset_busy", bus.busy, 0);
    check("midreset_done", bus.done, 0);
    check("midreset_addr", bus.mem_addr, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad_done = 0;
    bad_busy = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.done) bad_done++;
      if (bus.busy) bad_busy++;
    end
    check("no_done_after_reset", bad_done, 0);
    check("idle_after_reset", bad_busy, 0);
    do_run(1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < P; i++) ram[i] = 24'($urandom());
      do_run(1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dst_uart_dump.md
# dst_uart_dump

Downstream readout stage for the grayscale filter pipeline. After the filter has filled the destination pixel RAM, this block walks the RAM from address 0 upward and reads one 24-bit pixel per step. It takes the gray byte from each pixel and sends it out a UART TX line as 8N1 frames, so a host can capture the processed image. It owns the destination RAM's address bus while busy and never writes the RAM.

## Interface

Parameters:
- ADDR_BITS, 10, width of the RAM address bus.
- PIXELS, 1024, number of pixels dumped per run, addresses 0..PIXELS-1; legal range 1..2^ADDR_BITS.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- mem_addr  out  ADDR_BITS  read address to the destination RAM.
- mem_do  in  24  RAM read data; valid one cycle after mem_addr changes (synchronous read).
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last frame's stop bit completes.

## Operation

- Reset values: tx=1, busy=0, done=0, mem_addr=0, state=IDLE, bit and baud counters=0.
- FSM states:
  - IDLE: start=1 → FETCH, clears pixel index, busy=1.
  - FETCH: drives mem_addr=index → WAIT.
  - WAIT: one cycle for RAM latency → LOAD.
  - LOAD: latches shift register ← mem_do[7:0] → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If index=PIXELS-1 → DONE (or CSUM, see Configuration); else index+1 → FETCH.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- The gray byte is mem_do[7:0]. The filter writes equal R/G/B bytes; the upper 16 bits are ignored.
- Index counter is ADDR_BITS wide. It never wraps within a run because the terminal test is index=PIXELS-1. Each run restarts at 0.
- start while busy: ignored, no queuing.
- start in the same cycle as the DONE pulse: ignored. A new run needs start in IDLE.
- Reset mid-frame: tx forced to 1 asynchronously, frame truncated, no done pulse.
- mem_addr holds the last fetched address while idle.

## Timing

- start accepted at edge N: busy=1 after edge N, mem_addr valid after N+1, start bit begins after edge N+3.
- Per pixel: 3 overhead cycles (FETCH, WAIT, LOAD) + 10×CLKS_PER_BIT line cycles.
- Full run: 1 + PIXELS×(3 + 10×CLKS_PER_BIT) cycles from the start edge to the done pulse.
- Inter-frame gap: tx stays high for the 3 overhead cycles between frames.
- Baud counter counts 0..CLKS_PER_BIT-1 and the bit advances on terminal count. No fractional baud adjustment.
- tx is registered (no combinational path from state to pin).

## Configuration

- Macro: DST_UART_DUMP_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all transmitted pixel bytes is kept and cleared on run start.
  - After the last pixel's STOP, the FSM enters CSUM, sends one more 8N1 frame containing the XOR, then goes to DONE.
  - Run length grows by 10×CLKS_PER_BIT cycles; the 3-cycle overhead is not repeated.
- Undefined: the CSUM state and the XOR register are absent; STOP of the last pixel goes directly to DONE.

## Test plan

Bench uses CLKS_PER_BIT=4 and PIXELS=3, with RAM model contents 0x000000, 0xA5A5A5, 0xFFFF3C.

- Reset, no start for 100 cycles → tx=1, busy=0, done=0 throughout.
- Single start pulse → three frames decode to 0x00, 0xA5, 0x3C, LSB first, with start=0 and stop=1. Done pulses once at cycle 1+3×43=130 after the start edge.
- Addresses seen on mem_addr → 0, 1, 2 in order. Each byte is latched one cycle after its address is presented.
- Start re-pulsed at cycles 20 and 60 during the run → ignored; exactly three frames, one done.
- Reset asserted mid-DATA of frame 2 → tx=1 immediately, busy=0, no done. A fresh start after reset replays from address 0.
- With DST_UART_DUMP_CHECKSUM_EN → fourth frame 0x99 (0x00^0xA5^0x3C). Done arrives at cycle 170.
